// File: rtl/rob_commit_tracker_pkg.sv
// Shared sizing, tag/pointer types for the ROB commit tracker slice.
package rob_pkg;
  localparam int unsigned TAG_W     = 3;
  localparam int unsigned ROB_DEPTH = 1 << TAG_W;
  localparam int unsigned COMMIT_W  = 2;
  localparam int unsigned WB_W      = 2;
  localparam int unsigned CNT_W     = $clog2(COMMIT_W + 1);

  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [TAG_W:0]   rob_ptr_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;
endpackage

// File: rtl/rob_commit_tracker_if.sv
// Allocation, writeback and commit signals between the tag loop and the tracker.
interface rob_commit_tracker_if;
  import rob_pkg::*;

  rob_tag_t                alloc_tag;
  logic                    alloc_valid;
  rob_tag_t [WB_W-1:0]     wb_tag;
  logic [WB_W-1:0]         wb_valid;
  rob_tag_t [COMMIT_W-1:0] commited_tags;
  logic [COMMIT_W-1:0]     commited_tags_valid;
  rob_cnt_t                commit_count;
  rob_ptr_t                occupancy;
  logic                    protocol_err;

  modport master (
    output alloc_tag, alloc_valid, wb_tag, wb_valid,
    input  commited_tags, commited_tags_valid, commit_count, occupancy, protocol_err
  );

  modport slave (
    input  alloc_tag, alloc_valid, wb_tag, wb_valid,
    output commited_tags, commited_tags_valid, commit_count, occupancy, protocol_err
  );
endinterface

// File: rtl/rob_commit_tracker_order_queue.sv
// Program-order tag queue: one push and up to COMMIT_W pops per cycle.
module rob_order_queue
  import rob_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  rob_tag_t                push_tag,
  input  rob_cnt_t                pop_count,
  output rob_tag_t [COMMIT_W-1:0] oldest,
  output rob_ptr_t                occupancy,
  output logic                    full
);
  rob_tag_t mem [ROB_DEPTH];
  rob_ptr_t head;
  rob_ptr_t tail;

  assign occupancy = tail - head;
  assign full      = (head[TAG_W-1:0] == tail[TAG_W-1:0]) && (head[TAG_W] != tail[TAG_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push && !full) begin
        tail <= tail + rob_ptr_t'(1);
      end
      head <= head + rob_ptr_t'(pop_count);
    end
  end

  // Storage needs no reset: entries are only read below the occupancy bound.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[tail[TAG_W-1:0]] <= push_tag;
    end
  end

  always_comb begin
    rob_ptr_t idx;
    idx    = '0;
    oldest = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      idx       = head + rob_ptr_t'(k);
      oldest[k] = mem[idx[TAG_W-1:0]];
    end
  end
endmodule

// File: rtl/rob_commit_tracker.sv
// In-order retirement of ROB tags: tracks done/inflight per tag, retires oldest done prefix.
module rob_commit_tracker
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rob_commit_tracker_if.slave  bus
);
  logic [ROB_DEPTH-1:0]    done;
  logic [ROB_DEPTH-1:0]    inflight;
  logic [ROB_DEPTH-1:0]    done_nxt;
  logic [ROB_DEPTH-1:0]    inflight_nxt;
  logic                    err_nxt;
  logic                    err_q;
  rob_tag_t [COMMIT_W-1:0] oldest;
  rob_tag_t [COMMIT_W-1:0] ret_tags;
  logic [COMMIT_W-1:0]     ret_valid;
  rob_cnt_t                ret_count;
  rob_ptr_t                occ;
  logic                    full;

  rob_order_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.alloc_valid),
    .push_tag  (bus.alloc_tag),
    .pop_count (ret_count),
    .oldest    (oldest),
    .occupancy (occ),
    .full      (full)
  );

  // A slot retires only while every older slot also retires.
  always_comb begin
    logic run;
    run       = 1'b1;
    ret_valid = '0;
    ret_tags  = '0;
    ret_count = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (run && (rob_ptr_t'(k) < occ) && done[oldest[k]]) begin
        ret_valid[k] = 1'b1;
        ret_tags[k]  = oldest[k];
        ret_count    = ret_count + rob_cnt_t'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    done_nxt     = done;
    inflight_nxt = inflight;
    err_nxt      = 1'b0;
    for (int unsigned k = 0; k < COMMIT_W; k++) begin
      if (ret_valid[k]) begin
        done_nxt[ret_tags[k]]     = 1'b0;
        inflight_nxt[ret_tags[k]] = 1'b0;
      end
    end
    if (bus.alloc_valid) begin
      if (full) begin
        err_nxt = 1'b1;
      end else begin
        if (inflight[bus.alloc_tag]) err_nxt = 1'b1;
        inflight_nxt[bus.alloc_tag] = 1'b1;
        done_nxt[bus.alloc_tag]     = 1'b0;
      end
    end
    for (int unsigned i = 0; i < WB_W; i++) begin
      if (bus.wb_valid[i]) begin
        if (inflight[bus.wb_tag[i]]) done_nxt[bus.wb_tag[i]] = 1'b1;
        else                         err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      done     <= done_nxt;
      inflight <= inflight_nxt;
      err_q    <= err_q | err_nxt;
    end
  end

  assign bus.commited_tags       = ret_tags;
  assign bus.commited_tags_valid = ret_valid;
  assign bus.commit_count        = ret_count;
  assign bus.occupancy           = occ;
  assign bus.protocol_err        = err_q;
endmodule

// File: tb/tb_rob_commit_tracker.sv
// Directed-vector bench for rob_commit_tracker (ROB_DEPTH=8, COMMIT_W=2, WB_W=2).
module tb_rob_commit_tracker;
  import rob_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rob_commit_tracker_if bus ();

  rob_commit_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_tag   = '0;
    bus.wb_valid    = '0;
    bus.wb_tag      = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_alloc(input rob_tag_t t);
    bus.alloc_tag   = t;
    bus.alloc_valid = 1'b1;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input logic [1:0] v, input rob_tag_t t0, input rob_tag_t t1);
    bus.wb_valid  = v;
    bus.wb_tag[0] = t0;
    bus.wb_tag[1] = t1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    vectors++;
    if (bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL reset_valid: got %b want 00", bus.commited_tags_valid);
    end
    vectors++;
    if (bus.occupancy !== 4'd0) begin
      miscompares++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy);
    end
    vectors++;
    if (bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want 0", bus.protocol_err);
    end
    vectors++;
    if (bus.commit_count !== 2'd0 || bus.commited_tags !== 6'd0) begin
      miscompares++; $display("FAIL reset_tags: got cnt %0d tags %h want 0/0", bus.commit_count, bus.commited_tags);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    do_alloc(3'd0); do_alloc(3'd1); do_alloc(3'd2);
    vectors++;
    if (bus.occupancy !== 4'd3) begin
      miscompares++; $display("FAIL ooo_occ_alloc: got %0d want 3", bus.occupancy);
    end
    set_wb(2'b01, 3'd1, 3'd0); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL ooo_nocommit: got %b want 00", bus.commited_tags_valid);
    end
    set_wb(2'b01, 3'd0, 3'd0); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b11 || bus.commited_tags !== {3'd1, 3'd0}) begin
      miscompares++; $display("FAIL ooo_commit: got valid %b tags %h want 11 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd1, 3'd0});
    end
    vectors++;
    if (bus.commit_count !== 2'd2 || bus.occupancy !== 4'd3) begin
      miscompares++; $display("FAIL ooo_count: got cnt %0d occ %0d want 2/3", bus.commit_count, bus.occupancy);
    end
    step();
    vectors++;
    if (bus.occupancy !== 4'd1 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL ooo_after: got occ %0d valid %b want 1/00", bus.occupancy, bus.commited_tags_valid);
    end
    vectors++;
    if (bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL ooo_err: got %b want 0", bus.protocol_err);
    end
  endtask

  task automatic test_width_limit();
    do_reset();
    do_alloc(3'd0); do_alloc(3'd1); do_alloc(3'd2);
    set_wb(2'b11, 3'd0, 3'd1); step();
    vectors++;
    if (bus.commited_tags_valid !== 2'b11 || bus.commited_tags !== {3'd1, 3'd0}) begin
      miscompares++; $display("FAIL width_a: got valid %b tags %h want 11 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd1, 3'd0});
    end
    set_wb(2'b01, 3'd2, 3'd0); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b01 || bus.commited_tags !== {3'd0, 3'd2}) begin
      miscompares++; $display("FAIL width_b: got valid %b tags %h want 01 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd0, 3'd2});
    end
    vectors++;
    if (bus.commit_count !== 2'd1 || bus.occupancy !== 4'd1) begin
      miscompares++; $display("FAIL width_b_cnt: got cnt %0d occ %0d want 1/1", bus.commit_count, bus.occupancy);
    end
    step();
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL width_drain: got occ %0d valid %b want 0/00", bus.occupancy, bus.commited_tags_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_alloc(3'd0); do_alloc(3'd1);
    set_wb(2'b11, 3'd0, 3'd1); step(); idle();
    bus.alloc_tag = 3'd2; bus.alloc_valid = 1'b1;
    vectors++;
    if (bus.commit_count !== 2'd2) begin
      miscompares++; $display("FAIL b2b_count: got %0d want 2", bus.commit_count);
    end
    step(); idle();
    vectors++;
    if (bus.occupancy !== 4'd1 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL b2b_occ: got occ %0d valid %b want 1/00", bus.occupancy, bus.commited_tags_valid);
    end
    set_wb(2'b10, 3'd0, 3'd2); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b01 || bus.commited_tags !== {3'd0, 3'd2}) begin
      miscompares++; $display("FAIL b2b_commit: got valid %b tags %h want 01 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd0, 3'd2});
    end
    vectors++;
    if (bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL b2b_err: got %b want 0", bus.protocol_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(rob_tag_t'(i));
    vectors++;
    if (bus.occupancy !== 4'd8) begin
      miscompares++; $display("FAIL wrap_full: got %0d want 8", bus.occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      set_wb(2'b11, rob_tag_t'(2 * i), rob_tag_t'(2 * i + 1));
      step();
    end
    idle();
    step();
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL wrap_drain: got occ %0d valid %b want 0/00", bus.occupancy, bus.commited_tags_valid);
    end
    do_alloc(3'd5); do_alloc(3'd6); do_alloc(3'd7); do_alloc(3'd0);
    vectors++;
    if (bus.occupancy !== 4'd4) begin
      miscompares++; $display("FAIL wrap_occ4: got %0d want 4", bus.occupancy);
    end
    set_wb(2'b11, 3'd5, 3'd6); step();
    vectors++;
    if (bus.commited_tags_valid !== 2'b11 || bus.commited_tags !== {3'd6, 3'd5}) begin
      miscompares++; $display("FAIL wrap_c1: got valid %b tags %h want 11 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd6, 3'd5});
    end
    set_wb(2'b11, 3'd7, 3'd0); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b11 || bus.commited_tags !== {3'd0, 3'd7}) begin
      miscompares++; $display("FAIL wrap_c2: got valid %b tags %h want 11 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd0, 3'd7});
    end
    vectors++;
    if (bus.occupancy !== 4'd2) begin
      miscompares++; $display("FAIL wrap_occ2: got %0d want 2", bus.occupancy);
    end
    step();
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL wrap_end: got occ %0d err %b want 0/0", bus.occupancy, bus.protocol_err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    set_wb(2'b01, 3'd3, 3'd0); step(); idle();
    vectors++;
    if (bus.protocol_err !== 1'b1 || bus.occupancy !== 4'd0 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL err_wb: got err %b occ %0d valid %b want 1/0/00",
                              bus.protocol_err, bus.occupancy, bus.commited_tags_valid);
    end
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(rob_tag_t'(i));
    vectors++;
    if (bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL err_prefull: got %b want 0", bus.protocol_err);
    end
    do_alloc(3'd5);
    vectors++;
    if (bus.occupancy !== 4'd8 || bus.protocol_err !== 1'b1) begin
      miscompares++; $display("FAIL err_full: got occ %0d err %b want 8/1", bus.occupancy, bus.protocol_err);
    end
    set_wb(2'b11, 3'd0, 3'd1); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b11 || bus.commited_tags !== {3'd1, 3'd0}) begin
      miscompares++; $display("FAIL err_full_intact: got valid %b tags %h want 11 tags %h",
                              bus.commited_tags_valid, bus.commited_tags, {3'd1, 3'd0});
    end
    do_reset();
    do_alloc(3'd2); do_alloc(3'd2);
    vectors++;
    if (bus.protocol_err !== 1'b1 || bus.occupancy !== 4'd2) begin
      miscompares++; $display("FAIL err_dup_alloc: got err %b occ %0d want 1/2", bus.protocol_err, bus.occupancy);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_alloc(3'd0); do_alloc(3'd1); do_alloc(3'd2); do_alloc(3'd3);
    set_wb(2'b11, 3'd1, 3'd2); step(); idle();
    vectors++;
    if (bus.occupancy !== 4'd4 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL mid_pre: got occ %0d valid %b want 4/00", bus.occupancy, bus.commited_tags_valid);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.commited_tags_valid !== 2'b00) begin
      miscompares++; $display("FAIL mid_in_reset: got occ %0d valid %b want 0/00", bus.occupancy, bus.commited_tags_valid);
    end
    reset = 1'b0;
    repeat (3) step();
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.commited_tags_valid !== 2'b00 || bus.protocol_err !== 1'b0) begin
      miscompares++; $display("FAIL mid_after: got occ %0d valid %b err %b want 0/00/0",
                              bus.occupancy, bus.commited_tags_valid, bus.protocol_err);
    end
    do_alloc(3'd4);
    set_wb(2'b01, 3'd4, 3'd0); step(); idle();
    vectors++;
    if (bus.commited_tags_valid !== 2'b01 || bus.commited_tags !== {3'd0, 3'd4} || bus.occupancy !== 4'd1) begin
      miscompares++; $display("FAIL mid_resume: got valid %b tags %h occ %0d want 01 tags %h occ 1",
                              bus.commited_tags_valid, bus.commited_tags, bus.occupancy, {3'd0, 3'd4});
    end
    step();
    vectors++;
    if (bus.occupancy !== 4'd0) begin
      miscompares++; $display("FAIL mid_drain: got %0d want 0", bus.occupancy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();
    test_reset();
    test_out_of_order();
    test_width_limit();
    test_back_to_back();
    test_wrap();
    test_errors();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
